// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receive-side constants and the rx entry layout.
//   UART_DATA_W     - frame data width delivered by the receiver
//   UART_FIFO_DEPTH - default receive buffer depth
//   uart_rx_entry_t - one buffered frame: parity-error flag above the data
package uart_pkg;

    localparam int UART_DATA_W     = 9;
    localparam int UART_FIFO_DEPTH = 16;

    typedef struct packed {
        logic                   err;
        logic [UART_DATA_W-1:0] data;
    } uart_rx_entry_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: generic synchronous FIFO using wrap-bit pointers.
//   clk_i, rst_ni       - clock, asynchronous active-low reset
//   push_i, wdata_i     - write request and data
//   pop_i               - read request (ignored when empty)
//   clear_i             - synchronous flush, overrides push and pop
//   rdata_o             - head entry, driven combinationally (0 when empty)
//   full_o, empty_o     - occupancy flags
//   level_o             - occupancy, 0..DEPTH
//   push_ok_o, pop_ok_o - request would be accepted this cycle (before clear)
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH = UART_FIFO_DEPTH,
    parameter  int W     = UART_DATA_W + 1,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         clear_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o,
    output logic [AW:0]  level_o,
    output logic         push_ok_o,
    output logic         pop_ok_o
);

    logic [AW:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [W-1:0] mem_q [DEPTH];

    assign empty_o   = wptr_q == rptr_q;
    assign full_o    = (wptr_q ^ rptr_q) == {1'b1, {AW{1'b0}}};
    assign level_o   = wptr_q - rptr_q;
    assign pop_ok_o  = pop_i & ~empty_o;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
    assign push_ok_o = push_i & (~full_o | pop_ok_o);
    // Gating keeps the output at 0 while empty, since storage is never reset.
    assign rdata_o   = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = clear_i ? '0 : wptr_q + (AW+1)'(push_ok_o);
        rptr_d = clear_i ? '0 : rptr_q + (AW+1)'(pop_ok_o);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok_o && !clear_i) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive buffer capturing one frame per rising edge of rx_rdy_i.
//   clk_i, rst_ni              - clock, asynchronous active-low reset
//   clk_en_i                   - bit-rate strobe (paces the idle timeout only)
//   en_i                       - receive enable, gates pushes
//   rx_data_i, rx_rdy_i, rx_err_i - receiver frame, ready level, parity error
//   pop_i, clear_i             - consumer pop, synchronous flush
//   watermark_i                - irq_wm_o threshold, 0 disables
//   rd_valid_o, rd_data_o, rd_err_o - head entry presentation
//   level_o, full_o            - occupancy
//   overflow_o                 - sticky dropped-frame flag, cleared by clear_i
//   irq_wm_o                   - level >= watermark_i (registered)
//   irq_timeout_o              - idle timeout, built only with UART_RX_FIFO_TIMEOUT_EN
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH        = UART_FIFO_DEPTH,
    parameter  int DATA_W       = UART_DATA_W,
`ifdef UART_RX_FIFO_TIMEOUT_EN
    parameter  int TIMEOUT_BITS = 32,
`endif
    localparam int LVL_W        = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clk_en_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] rx_data_i,
    input  logic              rx_rdy_i,
    input  logic              rx_err_i,
    input  logic              pop_i,
    input  logic              clear_i,
    input  logic [LVL_W-1:0]  watermark_i,
    output logic              rd_valid_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_err_o,
    output logic [LVL_W-1:0]  level_o,
    output logic              full_o,
    output logic              overflow_o,
    output logic              irq_wm_o,
    output logic              irq_timeout_o
);

    logic              rdy_q;
    logic              ovf_q, ovf_d;
    logic              wm_q, wm_d;
    logic              push_ev, push_ok, pop_ok, empty;
    logic [DATA_W:0]   head;
    logic [LVL_W-1:0]  level_d;

    // Edge detect: a held ready level produces exactly one push.
    assign push_ev = rx_rdy_i & ~rdy_q & en_i;

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .W     (DATA_W + 1)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push_i    (push_ev),
        .pop_i     (pop_i),
        .clear_i   (clear_i),
        .wdata_i   ({rx_err_i, rx_data_i}),
        .rdata_o   (head),
        .full_o    (full_o),
        .empty_o   (empty),
        .level_o   (level_o),
        .push_ok_o (push_ok),
        .pop_ok_o  (pop_ok)
    );

    assign rd_valid_o = ~empty;
    assign rd_err_o   = head[DATA_W];
    assign rd_data_o  = head[DATA_W-1:0];
    assign overflow_o = ovf_q;
    assign irq_wm_o   = wm_q;

    always_comb begin
        level_d = clear_i ? '0 : level_o + LVL_W'(push_ok) - LVL_W'(pop_ok);
        ovf_d   = clear_i ? 1'b0 : ovf_q | (push_ev & ~push_ok);
        wm_d    = (watermark_i != '0) && (level_d >= watermark_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdy_q <= 1'b0;
            ovf_q <= 1'b0;
            wm_q  <= 1'b0;
        end else begin
            rdy_q <= rx_rdy_i;
            ovf_q <= ovf_d;
            wm_q  <= wm_d;
        end
    end

`ifdef UART_RX_FIFO_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_BITS + 1);

    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          to_q, to_d;

    // Counter saturates at TIMEOUT_BITS; the flag stays up until a pop or clear.
    always_comb begin
        to_cnt_d = (clear_i | push_ev | pop_ok) ? '0 :
                   (clk_en_i & ~empty & (to_cnt_q != TW'(TIMEOUT_BITS))) ? to_cnt_q + 1'b1 : to_cnt_q;
        to_d     = (clear_i | pop_ok) ? 1'b0 : to_q | (to_cnt_d == TW'(TIMEOUT_BITS));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            to_cnt_q <= '0;
            to_q     <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            to_q     <= to_d;
        end
    end

    assign irq_timeout_o = to_q;
`else
    logic unused_clk_en;
    assign unused_clk_en = clk_en_i;
    assign irq_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: randomized + directed bench with a queue-based reference model and scoreboard.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int TO    = 8;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       clk_en = 1'b0, en = 1'b1, rx_rdy = 1'b0, rx_err = 1'b0, pop = 1'b0, clear = 1'b0;
    logic [8:0] rx_data = '0;
    logic [4:0] wm = '0;
    logic       rd_valid, rd_err, full, overflow, irq_wm, irq_to;
    logic [8:0] rd_data;
    logic [4:0] level;

    always #5 clk = ~clk;

`ifdef UART_RX_FIFO_TIMEOUT_EN
    uart_rx_fifo #(.DEPTH(DEPTH), .TIMEOUT_BITS(TO)) dut (
`else
    uart_rx_fifo #(.DEPTH(DEPTH)) dut (
`endif
        .clk_i(clk), .rst_ni(rst_n), .clk_en_i(clk_en), .en_i(en),
        .rx_data_i(rx_data), .rx_rdy_i(rx_rdy), .rx_err_i(rx_err),
        .pop_i(pop), .clear_i(clear), .watermark_i(wm),
        .rd_valid_o(rd_valid), .rd_data_o(rd_data), .rd_err_o(rd_err),
        .level_o(level), .full_o(full), .overflow_o(overflow),
        .irq_wm_o(irq_wm), .irq_timeout_o(irq_to)
    );

    // Reference model: frames accepted so far live in exp_q; the unread window is
    // [rd_idx, exp_q.size()), flush_to marks entries discarded by clear/reset.
    logic [9:0] exp_q[$];
    int         m_cnt = 0, m_tc = 0, flush_to = 0;
    logic       m_ovf = 1'b0, m_wm = 1'b0, m_rdy = 1'b0, m_to = 1'b0;
    int         vectors = 0, miscompares = 0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_cnt = 0; m_ovf = 0; m_wm = 0; m_rdy = 0; m_tc = 0; m_to = 0;
            flush_to = exp_q.size();
        end else begin
            logic pe, po;
            pe = rx_rdy && !m_rdy && en;
            po = pop && m_cnt > 0;
`ifdef UART_RX_FIFO_TIMEOUT_EN
            if (clear || pe || po) m_tc = 0;
            else if (clk_en && m_cnt > 0 && m_tc < TO) m_tc++;
            m_to = (po || clear) ? 1'b0 : (m_to || m_tc == TO);
`endif
            m_rdy = rx_rdy;
            if (clear) begin
                m_cnt = 0; m_ovf = 0; flush_to = exp_q.size();
            end else begin
                if (po) m_cnt--;
                if (pe) begin
                    if (m_cnt < DEPTH) begin
                        exp_q.push_back({rx_err, rx_data});
                        m_cnt++;
                    end else m_ovf = 1;
                end
            end
            m_wm = (wm != 0) && (m_cnt >= int'(wm));
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: checks status each cycle and pops the scoreboard on every accepted read.
    initial begin
        int rd_idx = 0;
        forever begin
            @(negedge clk);
            if (rd_idx < flush_to) rd_idx = flush_to;
            chk("rd_valid", int'(rd_valid), int'(m_cnt > 0));
            chk("level", int'(level), m_cnt);
            chk("full", int'(full), int'(m_cnt == DEPTH));
            chk("overflow", int'(overflow), int'(m_ovf));
            chk("irq_wm", int'(irq_wm), int'(m_wm));
            chk("irq_timeout", int'(irq_to), int'(m_to));
            if (!rst_n) chk("reset_head", int'({rd_err, rd_data}), 0);
            else if (m_cnt > 0 && rd_idx < exp_q.size())
                chk("head", int'({rd_err, rd_data}), int'(exp_q[rd_idx]));
            if (rst_n && rd_valid && pop && rd_idx < exp_q.size()) rd_idx++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [8:0] d, input logic e);
        rx_data = d; rx_err = e; rx_rdy = 1'b1;
        cyc(2);
        rx_rdy = 1'b0;
        cyc(1);
    endtask

    task automatic do_clear();
        clear = 1'b1; cyc(1); clear = 1'b0; cyc(1);
    endtask

    initial begin
        cyc(3);
        rst_n = 1'b1;
        cyc(1);
        // long-held ready level gives a single entry
        rx_data = 9'h0A5; rx_rdy = 1'b1; cyc(50); rx_rdy = 1'b0; cyc(2);
        pop = 1'b1; cyc(1); pop = 1'b0; cyc(1);
        // overfill: 17 frames, the last is dropped
        for (int i = 0; i < 17; i++) frame(9'($urandom), i[0]);
        cyc(2);
        do_clear();
        // full FIFO with simultaneous push edge and pop
        for (int i = 0; i < 16; i++) frame(9'($urandom), 1'b0);
        rx_data = 9'h1C3; rx_rdy = 1'b1; pop = 1'b1; cyc(1);
        pop = 1'b0; cyc(3); rx_rdy = 1'b0; cyc(2);
        // drain including pops on empty
        pop = 1'b1; cyc(20); pop = 1'b0;
        // watermark
        wm = 5'd4;
        for (int i = 0; i < 4; i++) frame(9'($urandom), 1'b0);
        cyc(2); pop = 1'b1; cyc(1); pop = 1'b0; cyc(2);
        do_clear(); wm = '0;
        // error frame then clear coincident with a push, ready held afterwards
        frame(9'h155, 1'b1); cyc(1);
        rx_data = 9'h0F0; rx_rdy = 1'b1; clear = 1'b1; cyc(1);
        clear = 1'b0; cyc(5); rx_rdy = 1'b0; cyc(2);
        // idle timeout
        frame(9'h033, 1'b0);
        for (int i = 0; i < 10; i++) begin
            clk_en = 1'b1; cyc(1); clk_en = 1'b0; cyc(1);
        end
        pop = 1'b1; cyc(1); pop = 1'b0; cyc(2);
        // reset while frames are buffered
        for (int i = 0; i < 3; i++) frame(9'($urandom), 1'b1);
        rx_rdy = 1'b1; rx_data = 9'h111;
        @(posedge clk); #3;
        rst_n = 1'b0; rx_rdy = 1'b0;
        cyc(2); rst_n = 1'b1; cyc(2);
        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            if (rx_rdy) rx_rdy = ($urandom % 3) != 0;
            else if ($urandom % 4 == 0) begin
                rx_rdy = 1'b1; rx_data = 9'($urandom); rx_err = 1'($urandom);
            end
            pop    = (i < 1000) ? ($urandom % 5 == 0) : ($urandom % 2 == 0);
            clear  = ($urandom % 97) == 0;
            en     = ($urandom % 20) != 0;
            clk_en = 1'($urandom);
            if (i % 100 == 0) wm = 5'($urandom_range(0, 16));
            cyc(1);
        end
        rx_rdy = 1'b0; pop = 1'b0; clear = 1'b0;
        cyc(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
